// File: rtl/crc32_share_arbiter_if.sv
// Handshake bundle between frame requesters, the result consumer and the
// shared CRC-32 arbiter. master: requester/consumer side, slave: arbiter side.
interface crc32_share_arbiter_if #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int LEN_W = 16
);
    logic [N_REQ-1:0]    req_valid;
    logic [32*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]    req_last;
    logic [N_REQ-1:0]    req_ready;
    logic                res_valid;
    logic                res_ready;
    logic [31:0]         res_crc;
    logic [ID_W-1:0]     res_id;
    logic [LEN_W-1:0]    res_len;
    logic                busy;

    modport master (
        output req_valid, req_data, req_last, res_ready,
        input  req_ready, res_valid, res_crc, res_id, res_len, busy
    );

    modport slave (
        input  req_valid, req_data, req_last, res_ready,
        output req_ready, res_valid, res_crc, res_id, res_len, busy
    );
endinterface

// File: rtl/crc32_share_arbiter.sv
// Shares one 32-bit parallel CRC-32 engine (poly 04C11DB7, MSB-first) among
// N_REQ frame requesters, granting per frame in round-robin order.
// Ports: clk, rst_n (async, asserted high), bus (slave): req_valid/req_data/
// req_last/req_ready per requester, res_valid/res_ready/res_crc/res_id/
// res_len result handshake, busy (state not IDLE).
module crc32_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2,
    parameter int LEN_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    crc32_share_arbiter_if.slave  bus
);
    localparam logic [31:0]     POLY    = 32'h04C11DB7;
    localparam logic [31:0]     SEED    = 32'hFFFFFFFF;
    localparam logic [ID_W:0]   NR      = (ID_W+1)'(N_REQ);
    localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_REQ - 1);

    typedef enum logic [1:0] {IDLE, STREAM, RESULT} state_t;

    state_t             state;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    grant;
    logic [31:0]        crc;
    logic [LEN_W-1:0]   cnt;
    logic [N_REQ-1:0]   ready_r;
    logic               res_valid_r;
    logic [31:0]        res_crc_r;
    logic [ID_W-1:0]    res_id_r;
    logic [LEN_W-1:0]   res_len_r;
    logic               busy_r;

    logic [31:0]        words [N_REQ];
    logic [31:0]        gdata;
    logic               gvalid;
    logic               glast;
    logic               accept;
    logic [31:0]        crc_next;
    logic [LEN_W-1:0]   cnt_inc;
    logic [ID_W-1:0]    pick;
    logic               found;
    logic [ID_W:0]      sum;

    // 32 steps of the shift/xor recurrence, unrolled into one cycle
    function automatic logic [31:0] a32(input logic [31:0] s_in);
        logic [31:0] s;
        s = s_in;
        for (int k = 0; k < 32; k++) begin
            s = {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0);
        end
        return s;
    endfunction

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            words[i] = bus.req_data[32*i +: 32];
        end
    end

    assign gdata    = words[grant];
    assign gvalid   = bus.req_valid[grant];
    assign glast    = bus.req_last[grant];
    assign accept   = ready_r[grant] & gvalid;
    assign crc_next = a32(crc ^ gdata);
    assign cnt_inc  = (&cnt) ? cnt : cnt + 1'b1;

    // first valid requester at or after rr_ptr, wrapping
    always_comb begin
        found = 1'b0;
        pick  = '0;
        sum   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
            if (sum >= NR) begin
                sum = sum - NR;
            end
            if (!found && bus.req_valid[sum[ID_W-1:0]]) begin
                found = 1'b1;
                pick  = sum[ID_W-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            grant       <= '0;
            crc         <= SEED;
            cnt         <= '0;
            ready_r     <= '0;
            res_valid_r <= 1'b0;
            res_crc_r   <= '0;
            res_id_r    <= '0;
            res_len_r   <= '0;
            busy_r      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        grant         <= pick;
                        crc           <= SEED;
                        cnt           <= '0;
                        ready_r       <= '0;
                        ready_r[pick] <= 1'b1;
                        busy_r        <= 1'b1;
                        state         <= STREAM;
                    end
                end
                STREAM: begin
                    if (accept) begin
                        crc <= crc_next;
                        cnt <= cnt_inc;
                        if (glast) begin
                            res_crc_r   <= crc_next;
                            res_id_r    <= grant;
                            res_len_r   <= cnt_inc;
                            res_valid_r <= 1'b1;
                            ready_r     <= '0;
                            state       <= RESULT;
                        end
                    end
                end
                RESULT: begin
                    if (bus.res_ready) begin
                        res_valid_r <= 1'b0;
                        rr_ptr      <= (grant == LAST_ID) ? '0
                                                          : grant + 1'b1;
                        busy_r      <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready = ready_r;
    assign bus.res_valid = res_valid_r;
    assign bus.res_crc   = res_crc_r;
    assign bus.res_id    = res_id_r;
    assign bus.res_len   = res_len_r;
    assign bus.busy      = busy_r;
endmodule

// File: tb/tb_crc32_share_arbiter.sv
// Self-checking bench for crc32_share_arbiter: table vectors, hand-written
// corner sequences and random frames against a bit-serial CRC model.
module tb_crc32_share_arbiter;
    localparam logic [31:0] POLY = 32'h04C11DB7;

    logic clk;
    logic rst_n;

    crc32_share_arbiter_if #(.N_REQ(4), .ID_W(2), .LEN_W(16)) bus ();
    crc32_share_arbiter_if #(.N_REQ(4), .ID_W(2), .LEN_W(4))  bus2 ();

    crc32_share_arbiter #(.N_REQ(4), .ID_W(2), .LEN_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    crc32_share_arbiter #(.N_REQ(4), .ID_W(2), .LEN_W(4)) dut_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] fw [0:63];
    int fn;

    typedef struct {
        int          id;
        int          n;
        logic [31:0] base;
        int          gap_at;
        int          gap_len;
        int          hold;
        bit          known;
        logic [31:0] exp_crc;
    } vec_t;

    vec_t vt [5];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // bit-serial reference: one data bit per shift, MSB first
    function automatic logic [31:0] crc_step(input logic [31:0] c,
                                             input logic [31:0] w);
        logic [31:0] r;
        logic fb;
        r = c;
        for (int b = 31; b >= 0; b--) begin
            fb = r[31] ^ w[b];
            r  = {r[30:0], 1'b0};
            if (fb) r = r ^ POLY;
        end
        return r;
    endfunction

    function automatic logic [31:0] model_crc(input int n);
        logic [31:0] r;
        r = 32'hFFFFFFFF;
        for (int k = 0; k < n; k++) r = crc_step(r, fw[k]);
        return r;
    endfunction

    task automatic send_frame(input int id, input int gap_at,
                              input int gap_len);
        int idx;
        int g;
        int budget;
        idx = 0;
        g = 0;
        budget = 0;
        while (idx < fn) begin
            @(negedge clk);
            budget++;
            if (budget > 500) begin
                chk("send_timeout", 1, 0);
                break;
            end
            if (idx == gap_at && g < gap_len) begin
                bus.req_valid[id] = 1'b0;
                g++;
            end else begin
                bus.req_valid[id]        = 1'b1;
                bus.req_data[32*id +: 32] = fw[idx];
                bus.req_last[id]         = (idx == fn - 1);
                if (bus.req_ready[id]) idx++;
            end
        end
        @(negedge clk);
        bus.req_valid[id] = 1'b0;
        bus.req_last[id]  = 1'b0;
        chk("res_latency", bus.res_valid, 1);
    endtask

    task automatic result_check(input logic [31:0] ec, input int eid,
                                input int elen, input int hold);
        int b;
        b = 0;
        while (!bus.res_valid && b < 200) begin
            @(negedge clk);
            b++;
        end
        chk("res_valid", bus.res_valid, 1);
        chk("res_crc", bus.res_crc, ec);
        chk("res_id", bus.res_id, eid);
        chk("res_len", bus.res_len, elen);
        if (hold > 0) bus.req_valid = '1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("stall_valid", bus.res_valid, 1);
            chk("stall_crc", bus.res_crc, ec);
            chk("stall_id", bus.res_id, eid);
            chk("stall_len", bus.res_len, elen);
            chk("stall_ready", bus.req_ready, 0);
        end
        bus.req_valid = '0;
        bus.req_last  = '0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        chk("res_drop", bus.res_valid, 0);
        chk("busy_idle", bus.busy, 0);
    endtask

    task automatic fill(input int n, input logic [31:0] base);
        fn = n;
        for (int k = 0; k < n; k++) begin
            fw[k] = base + 32'(k) * 32'h01010101;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
    endtask

    task automatic test_fairness();
        logic [31:0] fwd [4][2];
        int widx [4];
        bit pend [4];
        logic [31:0] exp_q [$];
        int order [5];
        int nres;
        int iter;
        int idle_cnt;
        logic [31:0] ec;
        order = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 4; i++) begin
            widx[i] = 0;
            pend[i] = 1'b0;
            fwd[i][0] = $urandom();
            fwd[i][1] = $urandom();
            bus.req_valid[i] = 1'b1;
            bus.req_data[32*i +: 32] = fwd[i][0];
            bus.req_last[i] = 1'b0;
        end
        bus.res_ready = 1'b1;
        do_reset();
        nres = 0;
        iter = 0;
        idle_cnt = 0;
        while (nres < 5 && iter < 200) begin
            @(negedge clk);
            iter++;
            for (int i = 0; i < 4; i++) begin
                if (pend[i]) begin
                    widx[i]++;
                    if (widx[i] == 2) begin
                        ec = crc_step(32'hFFFFFFFF, fwd[i][0]);
                        exp_q.push_back(crc_step(ec, fwd[i][1]));
                        widx[i] = 0;
                        fwd[i][0] = $urandom();
                        fwd[i][1] = $urandom();
                    end
                end
                bus.req_data[32*i +: 32] = fwd[i][widx[i]];
                bus.req_last[i] = (widx[i] == 1);
            end
            chk("ready_onehot", 64'($countones(bus.req_ready) <= 1), 1);
            if (!bus.busy) idle_cnt++;
            if (bus.res_valid) begin
                chk("fair_id", bus.res_id, order[nres]);
                if (exp_q.size() > 0) chk("fair_crc", bus.res_crc,
                                          exp_q.pop_front());
                else chk("fair_crc_missing", 0, 1);
                chk("fair_len", bus.res_len, 2);
                nres++;
            end
            for (int i = 0; i < 4; i++) pend[i] = bus.req_ready[i];
        end
        chk("fair_results", nres, 5);
        chk("fair_cycles", iter, 19);
        chk("fair_bubbles", idle_cnt, 4);
        bus.req_valid = '0;
        bus.req_last  = '0;
        @(negedge clk);
        bus.res_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int idx;
        int b;
        fill(4, 32'h5A5A0001);
        idx = 0;
        b = 0;
        while (idx < 2 && b < 50) begin
            @(negedge clk);
            b++;
            bus.req_valid[1] = 1'b1;
            bus.req_data[63:32] = fw[idx];
            bus.req_last[1] = 1'b0;
            if (bus.req_ready[1]) idx++;
        end
        chk("mid_words", idx, 2);
        @(negedge clk);
        rst_n = 1'b1;
        bus.req_valid = '0;
        #1;
        chk("mid_rst_ready", bus.req_ready, 0);
        chk("mid_rst_valid", bus.res_valid, 0);
        chk("mid_rst_busy", bus.busy, 0);
        @(negedge clk);
        chk("mid_rst_crc", bus.res_crc, 0);
        chk("mid_rst_id", bus.res_id, 0);
        chk("mid_rst_len", bus.res_len, 0);
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("mid_no_result", bus.res_valid, 0);
        end
        fill(3, 32'h0BADF00D);
        send_frame(1, -1, 0);
        result_check(model_crc(3), 1, 3, 0);
    endtask

    task automatic test_saturation();
        int idx;
        int b;
        fn = 20;
        for (int k = 0; k < 20; k++) fw[k] = $urandom();
        idx = 0;
        b = 0;
        while (idx < 20 && b < 200) begin
            @(negedge clk);
            b++;
            bus2.req_valid[3] = 1'b1;
            bus2.req_data[127:96] = fw[idx];
            bus2.req_last[3] = (idx == 19);
            if (bus2.req_ready[3]) idx++;
        end
        @(negedge clk);
        bus2.req_valid = '0;
        bus2.req_last  = '0;
        chk("sat_valid", bus2.res_valid, 1);
        chk("sat_len", bus2.res_len, 15);
        chk("sat_crc", bus2.res_crc, model_crc(20));
        chk("sat_id", bus2.res_id, 3);
        bus2.res_ready = 1'b1;
        @(negedge clk);
        bus2.res_ready = 1'b0;
        chk("sat_drop", bus2.res_valid, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] c1;
        int id;
        int n;
        int ga;

        vt[0] = '{0, 1, 32'hFFFFFFFF, -1, 0, 0, 1'b1, 32'h00000000};
        vt[1] = '{3, 3, 32'h12345678, -1, 0, 0, 1'b0, 32'h0};
        vt[2] = '{1, 6, 32'hCAFEBABE, 3, 5, 0, 1'b0, 32'h0};
        vt[3] = '{2, 4, 32'h00000000, -1, 0, 10, 1'b0, 32'h0};
        vt[4] = '{1, 6, 32'hCAFEBABE, -1, 0, 0, 1'b0, 32'h0};

        rst_n = 1'b1;
        bus.req_valid  = '0;
        bus.req_data   = '0;
        bus.req_last   = '0;
        bus.res_ready  = 1'b0;
        bus2.req_valid = '0;
        bus2.req_data  = '0;
        bus2.req_last  = '0;
        bus2.res_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", bus.req_ready, 0);
        chk("rst_valid", bus.res_valid, 0);
        chk("rst_crc", bus.res_crc, 0);
        chk("rst_id", bus.res_id, 0);
        chk("rst_len", bus.res_len, 0);
        chk("rst_busy", bus.busy, 0);
        rst_n = 1'b0;

        bus.res_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_res_ready", {bus.res_valid, bus.busy}, 0);
        end
        bus.res_ready = 1'b0;

        for (int v = 0; v < 5; v++) begin
            fill(vt[v].n, vt[v].base);
            send_frame(vt[v].id, vt[v].gap_at, vt[v].gap_len);
            result_check(vt[v].known ? vt[v].exp_crc : model_crc(vt[v].n),
                         vt[v].id, vt[v].n, vt[v].hold);
        end

        fn = 4;
        for (int k = 0; k < 4; k++) fw[k] = $urandom();
        c1 = model_crc(4);
        send_frame(2, -1, 0);
        result_check(c1, 2, 4, 0);
        fw[4] = c1;
        fn = 5;
        send_frame(2, -1, 0);
        result_check(32'h00000000, 2, 5, 0);

        test_fairness();
        test_reset_mid();

        for (int r = 0; r < 20; r++) begin
            id = int'($urandom_range(0, 3));
            n  = int'($urandom_range(1, 6));
            ga = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, n-1))
                                             : -1;
            fn = n;
            for (int k = 0; k < n; k++) fw[k] = $urandom();
            send_frame(id, ga, int'($urandom_range(1, 4)));
            result_check(model_crc(n), id, n, int'($urandom_range(0, 3)));
        end

        test_saturation();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/crc32_share_arbiter.md
Name: crc32_share_arbiter

Overview:
- Shares one 32-bit parallel CRC-32 engine among N_REQ frame requesters, for example the switch ingress ports.
- Grants the engine to one requester per frame in round-robin order and streams that frame's 32-bit words through the engine.
- Returns the final CRC, the requester ID and the word count on a result handshake.
- Sits between the port ingress buffers and the FCS check/insert logic.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- ID_W, 2, requester ID width; must equal clog2(N_REQ).
- LEN_W, 16, width of the frame word counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- req_valid  in  N_REQ  bit i: requester i presents a word (a frame is pending).
- req_data  in  32*N_REQ  requester i word at [32i+31:32i].
- req_last  in  N_REQ  bit i: the current word of requester i is the last of its frame.
- req_ready  out  N_REQ  one-hot or zero; word accepted when req_valid[i] & req_ready[i].
- res_valid  out  1  result available.
- res_ready  in  1  result consumer accepts.
- res_crc  out  32  final CRC state of the frame.
- res_id  out  ID_W  requester that owned the frame.
- res_len  out  LEN_W  accepted word count, saturating.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset is rst_n, asynchronous, active-high; the clock is clk.
- While rst_n=1, all state is forced:
  - state=IDLE, rr_ptr=0, grant=0, crc=32'hFFFFFFFF, cnt=0.
  - req_ready=0, res_valid=0, res_crc=0, res_id=0, res_len=0, busy=0.
- CRC function:
  - Polynomial 0x04C11DB7, init 0xFFFFFFFF, no reflection, no final XOR.
  - A word is processed MSB-first. next = A32(crc ^ data), where A32 is 32 steps of the left-shift step s = (s<<1) ^ (s[31] ? 0x04C11DB7 : 0).
  - This is the same function as the team's existing 32-bit CRC datapath. The engine is instantiated internally and its state register is loadable, so it can be re-seeded per frame.
- State machine: IDLE, STREAM, RESULT.
- IDLE:
  - If any req_valid bit is set, grant the lowest index i >= rr_ptr with req_valid set, wrapping modulo N_REQ.
  - Load crc=FFFFFFFF and cnt=0, then go to STREAM.
  - req_ready stays 0 in IDLE, so there is a one-cycle arbitration bubble.
- STREAM:
  - req_ready[grant]=1; all other req_ready bits are 0.
  - On accept: crc <= next and cnt <= cnt+1, saturating at 2^LEN_W-1.
  - If req_valid[grant]=0, hold crc, cnt and grant. There is no timeout and no re-arbitration mid-frame.
  - Valid from other requesters is ignored until the frame ends.
  - On accept with req_last[grant]=1:
    - Register res_crc=next, res_id=grant, res_len=cnt+1 (saturated).
    - Set res_valid=1 and go to RESULT.
  - Result latency: res_valid rises one cycle after the last-word accept.
- RESULT:
  - req_ready=0.
  - res_valid and the res_* outputs are held stable until res_ready=1.
  - On the handshake: res_valid <= 0, rr_ptr <= (grant+1) mod N_REQ, go to IDLE.
  - res_ready=0 stalls the engine indefinitely (backpressure).
- The next grant is at the earliest one cycle after the result handshake, because IDLE is entered first.
- A one-word frame (valid and last on the first accept) is legal and gives cnt=1.
- res_ready asserted while res_valid=0 has no effect.
- Reset mid-frame abandons the frame; no result is emitted and rr_ptr returns to 0.
- req_data/req_last of non-granted requesters never affect state.

Test Plan:
- Single frame, requester 0: words 0xFFFFFFFF with last -> res_crc=0x00000000, res_id=0, res_len=1.
- Residue check: requester 2 sends a 4-word frame, then a second frame of the same 4 words plus the first frame's res_crc as a 5th word -> second res_crc=0x00000000, res_len=5, and the first res_crc matches the golden model.
- Fairness: requesters 0..3 all valid with 2-word frames continuously -> grant order 0,1,2,3,0.
  - req_ready is never multi-hot.
  - Each res_id matches the grant order.
  - One bubble cycle appears per frame.
- Stall and gap: res_ready=0 for 10 cycles -> res_* stable and req_ready all 0. A mid-frame req_valid gap of 5 cycles -> CRC equals the gap-free result.
- Reset mid-frame (rst_n=1 pulse after 2 words) -> outputs at reset values, no res_valid. The next frame from requester 1 gives the correct CRC from seed 0xFFFFFFFF.
- Counter saturation with LEN_W=4: a 20-word frame -> res_len=15 and the CRC is still correct.
